multicycle_ctrl: RTL and testbench

- Moore-style main controller for the multicycle ARM-subset core.
- Sequences one instruction at a time through fetch, decode, execute, memory and writeback states, and generates every datapath strobe.
- Drives the ImmSrc select of the immediate-extension unit, plus the ALU, mux and write-enable controls.
- Holds the architectural NZCV flags register and evaluates the condition field of each instruction.

---
 rtl/multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle ARM-subset core: state sequencing, datapath strobes, NZCV flags.
// Optional branch-with-link support (LINK state) is enabled by defining MCTRL_BL_EN.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ALUControl,
    output logic [3:0]  Flags,
    output logic        LinkSel
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
`ifdef MCTRL_BL_EN
        , S_LINK = 4'd10
`endif
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_flags;

    // Instr holds bits [31:12] of the instruction word
    logic [3:0]  w_cond, w_cmd, w_rd;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_unused_rn;
    assign w_cond      = Instr[19:16];
    assign w_op        = Instr[15:14];
    assign w_funct     = Instr[13:8];
    assign w_rd        = Instr[3:0];
    assign w_cmd       = w_funct[4:1];
    assign w_unused_rn = ^Instr[7:4];

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign Flags = r_flags;

    logic w_condex;
    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = ~w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = ~w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = ~w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = ~w_v;
            4'b1000: w_condex = w_c & ~w_z;
            4'b1001: w_condex = ~w_c | w_z;
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = ~w_z & (w_n == w_v);
            4'b1101: w_condex = w_z | (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    logic [1:0] w_alu_dec;
    logic       w_nowrite, w_cv_upd, w_alu_wr;
    always_comb begin
        w_alu_dec = 2'b00;
        w_nowrite = 1'b1;
        case (w_cmd)
            4'b0100: begin w_alu_dec = 2'b00; w_nowrite = 1'b0; end
            4'b0010: begin w_alu_dec = 2'b01; w_nowrite = 1'b0; end
            4'b0000: begin w_alu_dec = 2'b10; w_nowrite = 1'b0; end
            4'b1100: begin w_alu_dec = 2'b11; w_nowrite = 1'b0; end
            4'b1010: begin w_alu_dec = 2'b01; w_nowrite = 1'b1; end
            default: begin w_alu_dec = 2'b00; w_nowrite = 1'b1; end
        endcase
    end
    assign w_cv_upd = (w_cmd == 4'b0100) || (w_cmd == 4'b0010) || (w_cmd == 4'b1010);
    assign w_alu_wr = w_condex & ~w_nowrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if ((r_state == S_EXECR || r_state == S_EXECI) && w_funct[0] && w_condex) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_cv_upd)
                    r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign ImmSrc = (w_op == 2'b01) ? 2'b01 : (w_op == 2'b10) ? 2'b10 : 2'b00;
    assign RegSrc = {(w_op == 2'b01) && !w_funct[0], w_op == 2'b10};

    always_comb begin
        w_next     = r_state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        ALUControl = 2'b00;
        LinkSel    = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite = 1'b1; PCWrite = 1'b1;
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                case (w_op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
`ifdef MCTRL_BL_EN
                    2'b10:   w_next = w_funct[4] ? S_LINK : S_BRANCH;
`else
                    2'b10:   w_next = S_BRANCH;
`endif
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = w_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                if (w_condex && w_rd == 4'hF) PCWrite = 1'b1;
                else                          RegWrite = w_condex;
                w_next = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = w_condex;
                w_next   = S_FETCH;
            end
            S_EXECR: begin
                ALUControl = w_alu_dec;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dec;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                // a write to R15 is redirected to the PC enable
                if (w_alu_wr && w_rd == 4'hF) PCWrite = 1'b1;
                else                          RegWrite = w_alu_wr;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = w_condex;
                w_next    = S_FETCH;
            end
`ifdef MCTRL_BL_EN
            S_LINK: begin
                ResultSrc = 2'b11;
                LinkSel   = 1'b1;
                RegWrite  = w_condex;
                w_next    = S_BRANCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output bundles are queued per instruction and drained.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, LinkSel;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  Flags;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .ALUControl(ALUControl), .Flags(Flags),
        .LinkSel(LinkSel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] rs;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] imm;
        logic [1:0] rsrc;
        logic       regw;
        logic [1:0] aluc;
        logic [3:0] fl;
        logic       lnk;
    } exp_t;

    exp_t act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegSrc, RegWrite, ALUControl, Flags, LinkSel};

    exp_t  exp_q[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic exp_t z(input logic [1:0] imm, input logic [1:0] rsrc, input logic [3:0] fl);
        exp_t e;
        e = '0;
        e.imm = imm; e.rsrc = rsrc; e.fl = fl;
        return e;
    endfunction

    function automatic exp_t f_fetch(input logic [1:0] imm, input logic [1:0] rsrc, input logic [3:0] fl);
        exp_t e;
        e = z(imm, rsrc, fl);
        e.pcw = 1'b1; e.irw = 1'b1; e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10;
        return e;
    endfunction

    function automatic exp_t f_decode(input logic [1:0] imm, input logic [1:0] rsrc, input logic [3:0] fl);
        exp_t e;
        e = z(imm, rsrc, fl);
        e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10;
        return e;
    endfunction

    task automatic push(input exp_t e, input string n);
        exp_q.push_back(e);
        nm_q.push_back(n);
    endtask

    task automatic test_reset();
        exp_t e; string n;
        Instr = 20'hE2921; ALUFlags = 4'b0000; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = f_fetch(2'b00, 2'b00, 4'h0); e.pcw = 1'b0; e.irw = 1'b0;
        push(e, "rst_init_fetch");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
        reset = 1'b0;
        // SUBS R1,R0,R0 sets all four flags to a recognisable value
        Instr = 20'hE0501; ALUFlags = 4'b1011;
        push(f_fetch(2'b00, 2'b00, 4'h0), "rst_subs_fetch");
        push(f_decode(2'b00, 2'b00, 4'h0), "rst_subs_decode");
        e = z(2'b00, 2'b00, 4'h0); e.aluc = 2'b01; push(e, "rst_subs_execr");
        e = z(2'b00, 2'b00, 4'b1011); e.regw = 1'b1; push(e, "rst_subs_aluwb");
        Instr = 20'hE0501;
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
        Instr = 20'hE2921; ALUFlags = 4'b0110;
        push(f_fetch(2'b00, 2'b00, 4'b1011), "rst_adds_fetch");
        push(f_decode(2'b00, 2'b00, 4'b1011), "rst_adds_decode");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
        reset = 1'b1;
        e = z(2'b00, 2'b00, 4'b1011); e.asb = 2'b01; push(e, "rst_execi_abort");
        e = f_fetch(2'b00, 2'b00, 4'h0); e.pcw = 1'b0; e.irw = 1'b0; push(e, "rst_fetch_held");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic test_add_imm();
        exp_t e; string n;
        Instr = 20'hE2821; ALUFlags = 4'b1111;
        push(f_fetch(2'b00, 2'b00, 4'h0), "add_fetch_after_reset");
        push(f_decode(2'b00, 2'b00, 4'h0), "add_decode");
        e = z(2'b00, 2'b00, 4'h0); e.asb = 2'b01; push(e, "add_execi");
        e = z(2'b00, 2'b00, 4'h0); e.regw = 1'b1; push(e, "add_aluwb");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_ldr();
        exp_t e; string n;
        Instr = 20'hE5921; ALUFlags = 4'b0000;
        push(f_fetch(2'b01, 2'b00, 4'h0), "ldr_fetch");
        push(f_decode(2'b01, 2'b00, 4'h0), "ldr_decode");
        e = z(2'b01, 2'b00, 4'h0); e.asb = 2'b01; push(e, "ldr_memadr");
        e = z(2'b01, 2'b00, 4'h0); e.adr = 1'b1; push(e, "ldr_memrd");
        e = z(2'b01, 2'b00, 4'h0); e.rs = 2'b01; e.regw = 1'b1; push(e, "ldr_memwb");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_str();
        exp_t e; string n;
        Instr = 20'hE5821; ALUFlags = 4'b0000;
        push(f_fetch(2'b01, 2'b10, 4'h0), "str_fetch");
        push(f_decode(2'b01, 2'b10, 4'h0), "str_decode");
        e = z(2'b01, 2'b10, 4'h0); e.asb = 2'b01; push(e, "str_memadr");
        e = z(2'b01, 2'b10, 4'h0); e.adr = 1'b1; e.memw = 1'b1; push(e, "str_memwr");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    // SUBS then BEQ; fl_old is the flag value entering, af the ALU flags captured by SUBS
    task automatic test_subs_beq(input logic [3:0] fl_old, input logic [3:0] af, input logic taken);
        exp_t e; string n;
        Instr = 20'hE0501; ALUFlags = af;
        push(f_fetch(2'b00, 2'b00, fl_old), "subs_fetch");
        push(f_decode(2'b00, 2'b00, fl_old), "subs_decode");
        e = z(2'b00, 2'b00, fl_old); e.aluc = 2'b01; push(e, "subs_execr");
        e = z(2'b00, 2'b00, af); e.regw = 1'b1; push(e, "subs_aluwb_flags");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
        Instr = 20'h0A000; ALUFlags = 4'b0000;
        push(f_fetch(2'b10, 2'b01, af), "beq_fetch");
        push(f_decode(2'b10, 2'b01, af), "beq_decode");
        e = z(2'b10, 2'b01, af); e.asb = 2'b01; e.rs = 2'b10; e.pcw = taken;
        push(e, taken ? "beq_branch_taken" : "beq_branch_not_taken");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_cmp_orrs();
        exp_t e; string n;
        Instr = 20'hE1510; ALUFlags = 4'b0110;
        push(f_fetch(2'b00, 2'b00, 4'h0), "cmp_fetch");
        push(f_decode(2'b00, 2'b00, 4'h0), "cmp_decode");
        e = z(2'b00, 2'b00, 4'h0); e.aluc = 2'b01; push(e, "cmp_execr");
        e = z(2'b00, 2'b00, 4'b0110); push(e, "cmp_aluwb_nowrite");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
        // ORRS updates N,Z only: 0110 -> N=1,Z=0, C,V kept = 1010
        Instr = 20'hE1901; ALUFlags = 4'b1011;
        push(f_fetch(2'b00, 2'b00, 4'b0110), "orrs_fetch");
        push(f_decode(2'b00, 2'b00, 4'b0110), "orrs_decode");
        e = z(2'b00, 2'b00, 4'b0110); e.aluc = 2'b11; push(e, "orrs_execr");
        e = z(2'b00, 2'b00, 4'b1010); e.regw = 1'b1; push(e, "orrs_aluwb_nz_only");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_boundaries();
        exp_t e; string n;
        Instr = 20'hE282F; ALUFlags = 4'b0000;
        push(f_fetch(2'b00, 2'b00, 4'b1010), "pcwb_fetch");
        push(f_decode(2'b00, 2'b00, 4'b1010), "pcwb_decode");
        e = z(2'b00, 2'b00, 4'b1010); e.asb = 2'b01; push(e, "pcwb_execi");
        e = z(2'b00, 2'b00, 4'b1010); e.pcw = 1'b1; push(e, "pcwb_aluwb_r15");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
        Instr = 20'hF2821;
        push(f_fetch(2'b00, 2'b00, 4'b1010), "never_fetch");
        push(f_decode(2'b00, 2'b00, 4'b1010), "never_decode");
        e = z(2'b00, 2'b00, 4'b1010); e.asb = 2'b01; push(e, "never_execi");
        e = z(2'b00, 2'b00, 4'b1010); push(e, "never_aluwb_blocked");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
        Instr = 20'hEC000;
        push(f_fetch(2'b00, 2'b00, 4'b1010), "undef_fetch");
        push(f_decode(2'b00, 2'b00, 4'b1010), "undef_decode");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_bl();
        exp_t e; string n;
        Instr = 20'hEB000; ALUFlags = 4'b0000;
        push(f_fetch(2'b10, 2'b01, 4'b1010), "bl_fetch_after_undef");
        push(f_decode(2'b10, 2'b01, 4'b1010), "bl_decode");
`ifdef MCTRL_BL_EN
        e = z(2'b10, 2'b01, 4'b1010); e.rs = 2'b11; e.lnk = 1'b1; e.regw = 1'b1;
        push(e, "bl_link");
`endif
        e = z(2'b10, 2'b01, 4'b1010); e.asb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1;
        push(e, "bl_branch");
        push(f_fetch(2'b10, 2'b01, 4'b1010), "bl_return_fetch");
        while (exp_q.size() != 0) begin
            #1; e = exp_q.pop_front(); n = nm_q.pop_front(); n_cmp++;
            if (act !== e) begin n_bad++; $display("FAIL %s: got %h want %h", n, act, e); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_imm();
        test_ldr();
        test_str();
        test_subs_beq(4'b0000, 4'b0100, 1'b1);
        test_subs_beq(4'b0100, 4'b0000, 1'b0);
        test_cmp_orrs();
        test_boundaries();
        test_bl();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
